// File: rtl/skip_pkg.sv
// Shared types and constants for the clock-skip ring configuration controller.
package skip_pkg;

  localparam int LEN = 16;

  function automatic int cw_of(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int CW = cw_of(LEN);

  // One-hot reload value: the ring restarts at phase 0.
  localparam logic [LEN-1:0] SEL_PHASE0 = LEN'(1);

  typedef enum logic [1:0] {IDLE, BUILD, WAIT, APPLY} state_t;

  // A full period can never be skipped, so the count saturates at LEN-1.
  function automatic logic [CW-1:0] clamp_nskip(input logic [CW-1:0] n);
    return (n >= CW'(LEN)) ? CW'(LEN - 1) : n;
  endfunction

endpackage

// File: rtl/skip_ctl_if.sv
// Request/status and skip-ring control bundle between system logic, skip_ctl and the ring.
interface skip_ctl_if;
  import skip_pkg::*;

  logic          EN;
  logic          REQ;
  logic [CW-1:0] NSKIP;
  logic          RB0;
  logic          BUSY;
  logic          ACK;
  logic [CW-1:0] CUR_NSKIP;
  logic          RING_RST;
  logic          RING_E;
  logic [LEN-1:0] RING_SEL;
  logic [LEN-1:0] RING_MASK;

  modport master (
    output EN, REQ, NSKIP, RB0,
    input  BUSY, ACK, CUR_NSKIP, RING_RST, RING_E, RING_SEL, RING_MASK
  );

  modport slave (
    input  EN, REQ, NSKIP, RB0,
    output BUSY, ACK, CUR_NSKIP, RING_RST, RING_E, RING_SEL, RING_MASK
  );

endinterface

// File: rtl/skip_maskgen.sv
// Bresenham spread of n skips over LEN bits, one bit per cycle, into a shadow mask.
module skip_maskgen
  import skip_pkg::*;
(
  input  logic           iCLK,
  input  logic           nRST,
  input  logic           start,
  input  logic [CW-1:0]  n,
  output logic           done,
  output logic [LEN-1:0] shadow
);

  localparam int IW = $clog2(LEN);

  logic          run;
  logic [IW-1:0] idx;
  logic [CW:0]   acc;
  logic [CW:0]   acc_sum;

  // acc stays below LEN between steps, so acc+n never exceeds 2*LEN-2.
  assign acc_sum = acc + {1'b0, n};
  // Asserted during the step that produces the last bit.
  assign done    = run && (idx == IW'(LEN - 1));

  // Clear on start, then emit bit idx each cycle until the last bit is written.
  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      run    <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      shadow <= '0;
    end else if (start) begin
      run    <= 1'b1;
      idx    <= '0;
      acc    <= '0;
      shadow <= '0;
    end else if (run) begin
      if (acc_sum >= (CW+1)'(LEN)) begin
        shadow[idx] <= 1'b1;
        acc         <= acc_sum - (CW+1)'(LEN);
      end else begin
        acc <= acc_sum;
      end
      idx <= idx + IW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/skip_ctl.sv
// Skip-ring configuration controller: builds a new skip mask, waits for ring
// phase 0, then reloads selector and mask on the same edge.
//
//   state | meaning
//   IDLE  | waiting for REQ (not sampled while ACK is high)
//   BUILD | maskgen computing the shadow mask, LEN cycles
//   WAIT  | waiting for RB0, a stopped ring, or the LEN-cycle timeout
//   APPLY | RING_RST high with the new mask; ACK follows
module skip_ctl
  import skip_pkg::*;
(
  input logic       iCLK,
  input logic       nRST,
  skip_ctl_if.slave bus
);

  state_t         state;
  logic           busy_q;
  logic           ack_q;
  logic [CW-1:0]  cur_q;
  logic [CW-1:0]  nskip_q;
  logic [CW-1:0]  wcnt;
  logic           ring_rst_q;
  logic           ring_e_q;
  logic [LEN-1:0] ring_mask_q;

  logic           mg_start;
  logic           mg_done;
  logic [LEN-1:0] shadow;

  // A request is taken only in a true idle cycle, never in the ACK cycle.
  assign mg_start = (state == IDLE) && !ack_q && bus.REQ;

  skip_maskgen u_maskgen (
    .iCLK   (iCLK),
    .nRST   (nRST),
    .start  (mg_start),
    .n      (nskip_q),
    .done   (mg_done),
    .shadow (shadow)
  );

  // Sequencing FSM with all ring-facing outputs registered.
  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      cur_q       <= '0;
      nskip_q     <= '0;
      wcnt        <= '0;
      ring_rst_q  <= 1'b1;
      ring_e_q    <= 1'b0;
      ring_mask_q <= '0;
    end else begin
      ring_e_q <= bus.EN;
      case (state)
        IDLE: begin
          ring_rst_q <= 1'b0;
          ack_q      <= 1'b0;
          if (mg_start) begin
            nskip_q <= clamp_nskip(bus.NSKIP);
            busy_q  <= 1'b1;
            state   <= BUILD;
          end
        end
        BUILD: begin
          if (mg_done) begin
            wcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A stopped ring or a non-one-hot ring has no phase to wait for.
          if (bus.RB0 || !ring_e_q || (wcnt == CW'(LEN))) begin
            ring_rst_q  <= 1'b1;
            ring_mask_q <= shadow;
            cur_q       <= nskip_q;
            state       <= APPLY;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        APPLY: begin
          ring_rst_q <= 1'b0;
          ack_q      <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.ACK       = ack_q;
  assign bus.CUR_NSKIP = cur_q;
  assign bus.RING_RST  = ring_rst_q;
  assign bus.RING_E    = ring_e_q;
  assign bus.RING_SEL  = SEL_PHASE0;
  assign bus.RING_MASK = ring_mask_q;

endmodule

// File: tb/tb_skip_ctl.sv
// Scoreboard bench for skip_ctl: stimulus pushes expected results, a monitor
// checks ACK timing, applied mask, count, BUSY window and RING_E each cycle.
module tb_skip_ctl;
  import skip_pkg::*;

  typedef struct {
    logic [LEN-1:0] mask;
    int             nskip;
    int             k;
    int             ack;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic en_s = 1'b0;
  logic nrst_s = 1'b0;
  exp_t q[$];
  logic [LEN-1:0] last_mask = '0;

  skip_ctl_if bus();

  skip_ctl dut (
    .iCLK (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    = cyc + 1;
    en_s   = bus.EN;
    nrst_s = nrst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: bit i set iff floor((i+1)N/LEN) > floor(iN/LEN), N clamped below LEN.
  function automatic int model_n(input int n);
    return (n >= LEN) ? LEN - 1 : n;
  endfunction

  function automatic logic [LEN-1:0] model_mask(input int n);
    logic [LEN-1:0] m;
    int nn;
    m  = '0;
    nn = model_n(n);
    for (int i = 0; i < LEN; i++)
      if (((i + 1) * nn) / LEN > (i * nn) / LEN) m[i] = 1'b1;
    return m;
  endfunction

  // Monitor: runs 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.ACK) begin
        if (q.size() == 0) begin
          check("ack_unexpected", 32'(bus.ACK), 32'd0);
        end else begin
          check("ack_cycle", 32'(cyc), 32'(q[0].ack));
          check("ack_mask", 32'(bus.RING_MASK), 32'(q[0].mask));
          check("ack_cur_nskip", 32'(bus.CUR_NSKIP), 32'(q[0].nskip));
          void'(q.pop_front());
        end
      end else if (q.size() != 0 && cyc >= q[0].ack) begin
        check("ack_present", 32'(bus.ACK), 32'd1);
        void'(q.pop_front());
      end
      if (nrst_s && bus.RING_RST && q.size() != 0) begin
        check("apply_cycle", 32'(cyc), 32'(q[0].ack - 1));
        check("apply_mask", 32'(bus.RING_MASK), 32'(q[0].mask));
      end
      check("busy", 32'(bus.BUSY),
            32'(q.size() != 0 && cyc >= q[0].k && cyc < q[0].ack));
      check("ring_e", 32'(bus.RING_E), 32'(nrst_s & en_s));
      check("ring_sel", 32'(bus.RING_SEL), 32'd1);
    end
  end

  // One request; RB0 rises d cycles into WAIT (d > LEN: never). Optional ignored second REQ.
  task automatic run_req(input int n, input bit en, input int d, input bit dup, input int n2);
    exp_t e;
    int w;
    @(negedge clk);
    bus.EN = en;
    repeat (2) @(negedge clk);
    bus.REQ   = 1'b1;
    bus.NSKIP = CW'(n);
    bus.RB0   = 1'b0;
    w = en ? ((d < LEN) ? d : LEN) : 0;
    e.k     = cyc + 1;
    e.mask  = model_mask(n);
    e.nskip = model_n(n);
    e.ack   = e.k + LEN + w + 2;
    q.push_back(e);
    last_mask = e.mask;
    while (q.size() != 0 && cyc < e.ack + 5) begin
      @(negedge clk);
      bus.REQ = dup && (cyc == e.k + 3);
      if (bus.REQ) bus.NSKIP = CW'(n2);
      bus.RB0 = (cyc >= e.k + LEN + d);
    end
    bus.REQ = 1'b0;
  endtask

  initial begin
    int k;
    exp_t e;
    bus.EN = 1'b0; bus.REQ = 1'b0; bus.NSKIP = '0; bus.RB0 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ring_rst", 32'(bus.RING_RST), 32'd1);
    check("rst_ring_mask", 32'(bus.RING_MASK), 32'd0);
    check("rst_ring_e", 32'(bus.RING_E), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_ack", 32'(bus.ACK), 32'd0);
    check("rst_cur", 32'(bus.CUR_NSKIP), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_release_ring_rst", 32'(bus.RING_RST), 32'd0);

    run_req(4, 1'b1, 0, 1'b0, 0);
    run_req(0, 1'b1, 0, 1'b0, 0);
    run_req(20, 1'b1, 0, 1'b0, 0);
    run_req(4, 1'b1, 5, 1'b0, 0);
    run_req(4, 1'b1, 99, 1'b0, 0);
    run_req(4, 1'b1, 0, 1'b1, 2);
    run_req(7, 1'b0, 99, 1'b0, 0);

    // REQ held high across ACK: the next request lands two edges after ACK.
    @(negedge clk);
    bus.EN = 1'b1; bus.RB0 = 1'b1;
    repeat (2) @(negedge clk);
    bus.REQ = 1'b1; bus.NSKIP = CW'(4);
    k = cyc + 1;
    e.mask = model_mask(4); e.nskip = 4;
    e.k = k;      e.ack = k + LEN + 2;      q.push_back(e);
    e.k = k + 20; e.ack = k + 20 + LEN + 2; q.push_back(e);
    last_mask = e.mask;
    while (q.size() != 0 && cyc < k + 45) begin
      @(negedge clk);
      if (cyc == k + 20) bus.REQ = 1'b0;
    end
    bus.REQ = 1'b0;

    // Reset at BUILD cycle 7: request dropped, mask cleared, no ACK afterwards.
    @(negedge clk);
    check("pre_reset_mask", 32'(bus.RING_MASK), 32'(last_mask));
    bus.REQ = 1'b1; bus.NSKIP = CW'(9);
    k = cyc + 1;
    e.mask = model_mask(9); e.nskip = 9; e.k = k; e.ack = k + LEN + 2;
    q.push_back(e);
    @(negedge clk);
    bus.REQ = 1'b0;
    while (cyc < k + 6) @(negedge clk);
    nrst = 1'b0;
    q.delete();
    @(negedge clk);
    check("midrst_ring_mask", 32'(bus.RING_MASK), 32'd0);
    check("midrst_ring_rst", 32'(bus.RING_RST), 32'd1);
    check("midrst_busy", 32'(bus.BUSY), 32'd0);
    check("midrst_cur", 32'(bus.CUR_NSKIP), 32'd0);
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_ring_rst_low", 32'(bus.RING_RST), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_req(int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 31)));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skip_ctl.md
# skip_ctl

Configuration controller for the clock-skip ring: accepts a request for "skip N of every LEN input clocks" and computes an evenly spread skip mask over LEN cycles. It then waits for the ring's phase-0 marker and reloads the ring selector and mask in one glitch-free step. It sits between the system control logic and the skip ring, drives all of the ring's control inputs, and samples its bit-0 output.

## Interface
- LEN, 16: ring length, and therefore the mask and selector width.
- CW, $clog2(LEN+1): width of the skip-count fields.
- iCLK  in  1: single clock. All state updates on the posedge.
- nRST  in  1: synchronous, active-low reset.
- EN  in  1: global skip enable, registered into RING_E.
- REQ  in  1: new-configuration request, sampled in IDLE only.
- NSKIP  in  CW: requested skip count per LEN cycles.
- RB0  in  1: ring phase-0 marker (selector bit 0).
- BUSY  out  1: high in any state other than IDLE.
- ACK  out  1: one-cycle pulse when the new configuration has been applied.
- CUR_NSKIP  out  CW: currently applied skip count.
- RING_RST  out  1: ring selector reload strobe.
- RING_E  out  1: ring rotate/skip enable.
- RING_SEL  out  LEN: ring reload value. Constant 1 (one-hot, bit 0).
- RING_MASK  out  LEN: applied skip mask.

## Operation
- Reset values: BUSY=0, ACK=0, CUR_NSKIP=0, RING_RST=1, RING_E=0, RING_SEL=1, RING_MASK=0, state IDLE.
  - RING_RST drops to 0 on the first edge after nRST goes high.
  - RING_E follows EN, one register stage behind.
- States: IDLE → BUILD → WAIT → APPLY → IDLE.
- IDLE
  - REQ=1 latches NSKIP and moves to BUILD.
  - NSKIP ≥ LEN is clamped to LEN−1, so a full period is never skipped.
  - Shadow mask, accumulator and bit index are all cleared.
- BUILD (exactly LEN cycles): Bresenham spread, one bit per cycle, i = 0..LEN−1.
  - acc' = acc + N.
  - If acc' ≥ LEN: shadow[i]=1 and acc' −= LEN.
  - Result: bit i is set iff floor((i+1)·N/LEN) > floor(i·N/LEN).
  - acc is CW+1 bits wide and never exceeds 2·LEN−2.
  - RING_MASK keeps its old value throughout BUILD.
- WAIT: moves to APPLY on the first cycle in which any of these holds:
  - RB0=1;
  - RING_E=0 (the ring is not rotating, so no phase constraint applies);
  - the wait counter reaches LEN (the ring is not one-hot; apply anyway).
- APPLY (1 cycle): RING_RST=1 and RING_MASK=shadow, both set on the same edge. CUR_NSKIP is updated. The next state is IDLE.
- Return to IDLE: on the edge leaving APPLY, RING_RST returns to 0 and ACK=1 for one cycle.
- Requests while BUSY:
  - REQ is ignored and produces no ACK. The requester must hold or retry after BUSY falls.
  - REQ is not sampled in the ACK cycle either; the state is IDLE, but the request is registered on the next edge.
- Reset mid-operation: nRST=0 in any state restores all reset values on that edge. The shadow mask is discarded and no ACK is issued.

## Timing
- All outputs are registered on the posedge iCLK.
- The ring samples these outputs on the following negedge, giving half a cycle of setup. No combinational path exists from any input to any output.
- Latency for REQ sampled at edge k:
  - BUILD occupies edges k+1..k+LEN;
  - w ≥ 0 WAIT edges follow, with w ≤ LEN;
  - APPLY is visible after edge k+LEN+w+1;
  - ACK is visible after edge k+LEN+w+2.
- The minimum request-to-ACK time is LEN+2 cycles.
- RING_MASK and RING_RST change on the same edge, so the ring never runs a partial period with a mixed old/new mask at phase 0.

## Structure
- Package skip_pkg holds:
  - the state enum (IDLE, BUILD, WAIT, APPLY);
  - the CW width function;
  - constant SEL_PHASE0 = 1.
- One sub-module, skip_maskgen, holds the accumulator, bit index and shadow register, with start/done strobes.
- The FSM, wait counter and output registers stay in skip_ctl.

## Test plan
- Reset: hold nRST=0 for 3 cycles → RING_RST=1, RING_MASK=0, RING_SEL=1, RING_E=0, BUSY=0. After release, RING_RST=0 one edge later.
- Nominal request, ring enabled: EN=1, REQ with NSKIP=4, RB0 already high → RING_MASK=0x8888, CUR_NSKIP=4, ACK exactly 18 cycles after the REQ edge.
- Mask boundaries:
  - NSKIP=0 → mask 0x0000.
  - NSKIP=20 → clamped to 15, mask 0xFFFE, CUR_NSKIP=15.
- Phase wait and timeout:
  - RB0 low for 5 WAIT cycles, then high → APPLY on the next edge, ACK at 23 cycles.
  - RB0 stuck low with EN=1 → APPLY after 16 WAIT cycles.
- Requests during BUSY: a second REQ with NSKIP=2 during BUILD → ignored, one ACK only, final mask 0x8888.
- Reset mid-BUILD: nRST=0 at BUILD cycle 7 → reset values on that edge, no ACK. The old mask is not restored; RING_MASK=0.
